// File: rtl/instr_fetch_mem.sv
// Instruction memory with a program-load write port and a stallable, in-order
// read pipeline of LATENCY stages. Faulted fetches return NOP with rsp_fault set.
module instr_fetch_mem #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 65536,
  parameter int                LATENCY   = 1,
  parameter int                BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] NOP       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int                OFF      = (BYTE_ADDR != 0) ? $clog2(DATA_W / 8) : 0;
  localparam int                IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << OFF) - 1);

  // Aligned and inside the array; the word index is kept full width so that
  // high bits beyond the array size are seen rather than truncated away.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] idx;
    idx = a >> OFF;
    return ((a & LOW_MASK) == '0) && ((idx >> IW) == '0);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;

  logic [IW-1:0] req_idx, ld_idx;
  logic          req_ok, ld_ok, stall, accept;

  logic [LATENCY-1:0]             vld_q, vld_d, flt_q, flt_d;
  logic [LATENCY-1:0][DATA_W-1:0] sd;

  assign req_idx   = IW'(req_addr >> OFF);
  assign ld_idx    = IW'(ld_addr >> OFF);
  assign req_ok    = addr_ok(req_addr);
  assign ld_ok     = addr_ok(ld_addr);
  assign stall     = vld_q[LATENCY-1] && !rsp_ready;
  assign req_ready = rst && !stall && !ld_en;
  assign accept    = req_valid && req_ready;

  // Memory is never reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (rst && ld_en && ld_ok) mem[ld_idx] <= ld_data;
    if (accept && req_ok)      rd_word     <= mem[req_idx];
  end

  always_comb begin
    vld_d = vld_q;
    flt_d = flt_q;
    if (!stall) begin
      vld_d[0] = accept;
      flt_d[0] = accept && !req_ok;
      for (int k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        flt_d[k] = flt_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      flt_q <= '0;
    end else begin
      vld_q <= vld_d;
      flt_q <= flt_d;
    end
  end

  // rd_word is only meaningful for a valid, unfaulted first stage.
  assign sd[0] = (vld_q[0] && !flt_q[0]) ? rd_word : NOP;

  generate
    if (LATENCY > 1) begin : g_dly
      logic [LATENCY-1:1][DATA_W-1:0] dat_q, dat_d;

      always_comb begin
        dat_d = dat_q;
        if (!stall) begin
          for (int k = 1; k < LATENCY; k++) dat_d[k] = sd[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) dat_q <= {(LATENCY-1){NOP}};
        else      dat_q <= dat_d;
      end

      for (genvar k = 1; k < LATENCY; k++) begin : g_sd
        assign sd[k] = dat_q[k];
      end
    end
  endgenerate

  assign rsp_valid = vld_q[LATENCY-1];
  assign rsp_fault = flt_q[LATENCY-1];
  assign rsp_instr = sd[LATENCY-1];

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: byte addressing, 3-cycle latency, small array.
module tb_instr_fetch_mem;
  localparam int          DW  = 32;
  localparam int          AW  = 32;
  localparam int          DEP = 256;
  localparam int          LAT = 3;
  localparam logic [31:0] NOPV = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, ld_en;
  logic [AW-1:0] req_addr, ld_addr;
  logic [DW-1:0] rsp_instr, ld_data;

  instr_fetch_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(LAT),
                    .BYTE_ADDR(1), .NOP(NOPV)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_fault(rsp_fault), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every handshake pops one expected response.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (!rsp_valid) begin
        chk("idle_nop", 64'({rsp_fault, rsp_instr}), 64'({1'b0, NOPV}));
      end else if (rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got instr %h fault %b with nothing outstanding",
                   rsp_instr, rsp_fault);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_instr", 64'(rsp_instr), 64'(mon_e.instr));
          chk("rsp_fault", 64'(rsp_fault), 64'(mon_e.fault));
          if (mon_e.lat) chk("latency", 64'(cyc - mon_e.acc), 64'(LAT - 1));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef,
                       input bit lat, output int waits);
    bit rdy;
    int acc;
    waits = 0;
    req_valid = 1'b1;
    req_addr  = a;
    do begin
      @(negedge clk);
      rdy = req_ready;
      acc = cyc + 1;
      waits++;
      @(posedge clk);
    end while (!rdy && waits < 50);
    chk("accept", 64'(rdy), 64'(1));
    if (rdy) sb.push_back('{ei, ef, acc, lat});
    #1 req_valid = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_instr", 64'(rsp_instr), 64'(NOPV));
    chk("rst_fault", 64'(rsp_fault), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;

    // load then fetch, word 5 (byte 20)
    ld(32'd20, 32'h8C220004);
    fetch(32'd20, 32'h8C220004, 1'b0, 1'b1, w);
    drain();

    // back-to-back throughput
    ld(32'd0, 32'hA0A0A0A0); ld(32'd4, 32'hA1A1A1A1);
    ld(32'd8, 32'hA2A2A2A2); ld(32'd12, 32'hA3A3A3A3);
    fetch(32'd0,  32'hA0A0A0A0, 1'b0, 1'b1, w); chk("b2b_wait0", 64'(w), 64'(1));
    fetch(32'd4,  32'hA1A1A1A1, 1'b0, 1'b1, w); chk("b2b_wait1", 64'(w), 64'(1));
    fetch(32'd8,  32'hA2A2A2A2, 1'b0, 1'b1, w); chk("b2b_wait2", 64'(w), 64'(1));
    fetch(32'd12, 32'hA3A3A3A3, 1'b0, 1'b1, w); chk("b2b_wait3", 64'(w), 64'(1));
    drain();

    // backpressure: pipeline fills, head response holds for 4 cycles
    ld(32'd16, 32'hB4B4B4B4); ld(32'd24, 32'hB6B6B6B6); ld(32'd32, 32'hB8B8B8B8);
    rsp_ready = 1'b0;
    fetch(32'd16, 32'hB4B4B4B4, 1'b0, 1'b0, w);
    fetch(32'd24, 32'hB6B6B6B6, 1'b0, 1'b0, w);
    fetch(32'd32, 32'hB8B8B8B8, 1'b0, 1'b0, w);
    req_valid = 1'b1; req_addr = 32'd40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(rsp_valid), 64'(1));
      chk("stall_instr", 64'(rsp_instr), 64'(32'hB4B4B4B4));
      chk("stall_fault", 64'(rsp_fault), 64'(0));
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      @(posedge clk);
    end
    #1 req_valid = 1'b0; rsp_ready = 1'b1;
    drain();

    // faults, plus misaligned and out-of-range loads that must be dropped
    ld(32'd8, 32'hC2C2C2C2);
    ld(32'd9, 32'hBAD00001);
    ld(32'd1032, 32'hBAD00002);
    fetch(32'd6,    NOPV,         1'b1, 1'b1, w);
    fetch(32'd1024, NOPV,         1'b1, 1'b1, w);
    fetch(32'd8,    32'hC2C2C2C2, 1'b0, 1'b1, w);
    drain();

    // reset with two requests in flight
    fetch(32'd12, 32'hA3A3A3A3, 1'b0, 1'b0, w);
    fetch(32'd16, 32'hB4B4B4B4, 1'b0, 1'b0, w);
    rst = 1'b0;
    sb.delete();
    ld_en = 1'b1; ld_addr = 32'd0; ld_data = 32'hDEADDEAD;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_instr", 64'(rsp_instr), 64'(NOPV));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1; ld_en = 1'b0;
    fetch(32'd0, 32'hA0A0A0A0, 1'b0, 1'b1, w);
    chk("first_after_rst", 64'(w), 64'(1));
    fetch(32'd20, 32'h8C220004, 1'b0, 1'b1, w);
    drain();
    repeat (6) @(posedge clk);
    #1;

    // load/fetch collision on the same word
    ld_en = 1'b1; ld_addr = 32'd28; ld_data = 32'hE7E7E7E7;
    req_valid = 1'b1; req_addr = 32'd28;
    @(negedge clk);
    chk("collide_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1 ld_en = 1'b0;
    fetch(32'd28, 32'hE7E7E7E7, 1'b0, 1'b1, w);
    chk("collide_next_accept", 64'(w), 64'(1));
    drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
